// File: rtl/stage0_flush_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : stage0_flush_driver_if
// Brief    : Request / ma_flush bundle between the flush driver and its users.
// Revision : 1.0
// ============================================================================
interface stage0_flush_driver_if #(
  parameter int PC_W = 64
);

  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] req_pc;
  logic [1:0]      req_kind;
  logic            flush_rdy;
  logic            flush_en;
  logic [PC_W-1:0] flush_pc;
  logic            flush_fence;
  logic            flush_sfence;
  logic            update_eepoch_en;
  logic            update_wepoch_en;
  logic            eepoch;
  logic            wepoch;
  logic            busy;
  logic [31:0]     flush_count;
  logic            err_misaligned;

  // The driver side: accepts requests and masters the ma_flush bus.
  modport master (
    input  req_valid, req_pc, req_kind, flush_rdy,
    output req_ready, flush_en, flush_pc, flush_fence, flush_sfence,
           update_eepoch_en, update_wepoch_en, eepoch, wepoch, busy,
           flush_count, err_misaligned
  );

  modport slave (
    output req_valid, req_pc, req_kind, flush_rdy,
    input  req_ready, flush_en, flush_pc, flush_fence, flush_sfence,
           update_eepoch_en, update_wepoch_en, eepoch, wepoch, busy,
           flush_count, err_misaligned
  );

endinterface

`default_nettype wire

// File: rtl/stage0_flush_driver.sv
`default_nettype none
// ============================================================================
// Module   : stage0_flush_driver
// Brief    : Queues redirect requests and issues them to stage0 as ma_flush
//            pulses, tracking shadow eEpoch/wEpoch. Option: FLUSH_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module stage0_flush_driver #(
  parameter int PC_W    = 64,
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2
) (
  input wire                    CLK,
  input wire                    RST_N,
  stage0_flush_driver_if.master bus
);

  localparam int               c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(DEPTH);
  localparam logic [3:0]       c_gap   = 4'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [PC_W-1:0]    r_pc_mem   [DEPTH];
  logic [1:0]         r_kind_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_pending;
  state_t             r_state;
  logic [3:0]         r_gap;
  logic               r_eepoch;
  logic               r_wepoch;
  logic [31:0]        r_flush_count;

  logic               w_push;
  logic               w_pop;
  logic               w_fire;
  logic               w_drop;
  logic               w_bad_pc;
  logic               w_in_issue;
  logic [PC_W-1:0]    w_head_pc;
  logic [1:0]         w_head_kind;

  assign bus.req_ready = (r_count != c_full);
  assign w_push        = bus.req_valid && bus.req_ready;
  assign w_head_pc     = r_pc_mem[r_rd_ptr];
  assign w_head_kind   = r_kind_mem[r_rd_ptr];
  assign w_in_issue    = (r_state == S_ISSUE);

`ifdef FLUSH_ALIGN_CHECK_EN
  assign w_bad_pc = w_head_pc[0];
`else
  assign w_bad_pc = 1'b0;
`endif

  // A misaligned head is discarded without waiting for stage0 readiness.
  assign w_drop = w_in_issue && w_bad_pc;
  assign w_fire = w_in_issue && bus.flush_rdy && !w_bad_pc;
  assign w_pop  = w_fire || w_drop;

  assign bus.flush_en         = w_fire;
  assign bus.flush_pc         = w_fire ? w_head_pc : '0;
  assign bus.flush_fence      = w_fire && (w_head_kind == 2'd2);
  assign bus.flush_sfence     = w_fire && (w_head_kind == 2'd3);
  assign bus.update_eepoch_en = w_fire && (w_head_kind == 2'd0);
  assign bus.update_wepoch_en = w_fire && (w_head_kind != 2'd0);
  assign bus.eepoch           = r_eepoch;
  assign bus.wepoch           = r_wepoch;
  assign bus.flush_count      = r_flush_count;
  assign bus.busy             = (r_count != '0) || (r_state != S_IDLE);

  // Payload storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= bus.req_pc;
      r_kind_mem[r_wr_ptr] <= bus.req_kind;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_pending     <= 1'b0;
      r_state       <= S_IDLE;
      r_gap         <= 4'd0;
      r_eepoch      <= 1'b0;
      r_wepoch      <= 1'b0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Lagged occupancy view gives a fresh entry one settle cycle before issue.
      r_pending <= (r_count != '0);

      if (w_fire) begin
        r_flush_count <= r_flush_count + 32'd1;
        if (w_head_kind == 2'd0) begin
          r_eepoch <= ~r_eepoch;
        end else begin
          r_wepoch <= ~r_wepoch;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_pending && (r_count != '0)) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_drop) begin
            r_state <= S_IDLE;
          end else if (w_fire) begin
            if (MIN_GAP == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
              r_gap   <= c_gap;
            end
          end
        end
        S_GAP: begin
          r_gap <= r_gap - 4'd1;
          if (r_gap <= 4'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FLUSH_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_misaligned = r_err;
`else
  assign bus.err_misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage0_flush_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage0_flush_driver
// Brief    : Self-checking bench for stage0_flush_driver (directed + random).
// Revision : 1.0
// ============================================================================
module tb_stage0_flush_driver;

  localparam int PC_W    = 64;
  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 2;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  stage0_flush_driver_if #(.PC_W(PC_W)) bus ();

  stage0_flush_driver #(
    .PC_W    (PC_W),
    .DEPTH   (DEPTH),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    RST_N         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.req_kind  = 2'd0;
    bus.flush_rdy = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic [1:0] kind);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    bus.req_kind  = kind;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge CLK);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.flush_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b en=%b busy=%b, required 1 0 0",
               bus.req_ready, bus.flush_en, bus.busy);
    end
    n_checks++;
    if (bus.flush_count !== 32'd0 || bus.eepoch !== 1'b0 || bus.wepoch !== 1'b0 ||
        bus.err_misaligned !== 1'b0 || bus.flush_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d ee=%b we=%b err=%b pc=%h, required all 0",
               bus.flush_count, bus.eepoch, bus.wepoch, bus.err_misaligned, bus.flush_pc);
    end
  endtask

  task automatic test_single_flush();
    apply_reset();
    bus.flush_rdy = 1'b1;
    push_one(64'h8000_0000, 2'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.flush_en !== 1'b0) begin
        n_fail++;
        $display("FAIL early_flush: cycle %0d after accept en=%b, required 0", c, bus.flush_en);
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.flush_en !== 1'b1 || bus.flush_pc !== 64'h8000_0000 ||
        bus.update_eepoch_en !== 1'b1 || bus.update_wepoch_en !== 1'b0 ||
        bus.flush_fence !== 1'b0 || bus.flush_sfence !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: en=%b pc=%h ee_en=%b we_en=%b f=%b sf=%b, required 1 80000000 1 0 0 0",
               bus.flush_en, bus.flush_pc, bus.update_eepoch_en, bus.update_wepoch_en,
               bus.flush_fence, bus.flush_sfence);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (bus.flush_en !== 1'b0 || bus.eepoch !== 1'b1 || bus.wepoch !== 1'b0 ||
        bus.flush_count !== 32'd1 || bus.flush_pc !== '0) begin
      n_fail++;
      $display("FAIL single_after: en=%b ee=%b we=%b count=%0d pc=%h, required 0 1 0 1 0",
               bus.flush_en, bus.eepoch, bus.wepoch, bus.flush_count, bus.flush_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] exp_q[$];
    int acc;
    int seen;
    int last;
    apply_reset();
    acc = 0;
    bus.flush_rdy = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_pc   = 64'h1000 + 64'(i * 16);
      bus.req_kind = 2'(i % 2);
      @(negedge CLK);
      if (i == 4) begin
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready: req_ready=%b after %0d accepts, required 0", bus.req_ready, acc);
        end
      end
      if (bus.req_ready === 1'b1) begin
        exp_q.push_back(bus.req_pc);
        acc++;
      end
      @(posedge CLK);
      #1;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (acc != DEPTH) begin
      n_fail++;
      $display("FAIL accept_count: accepted=%0d, required %0d", acc, DEPTH);
    end
    bus.flush_rdy = 1'b1;
    seen = 0;
    last = -100;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.flush_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || bus.flush_pc !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_order: flush %0d pc=%h, required %h", seen, bus.flush_pc,
                   (exp_q.size() != 0) ? exp_q[0] : 64'h0);
        end
        if (seen > 0) begin
          n_checks++;
          if (c - last != MIN_GAP + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: spacing=%0d, required %0d", c - last, MIN_GAP + 2);
          end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last = c;
        seen++;
      end
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (seen != DEPTH) begin
      n_fail++;
      $display("FAIL b2b_total: flushes=%0d, required %0d", seen, DEPTH);
    end
  endtask

  task automatic test_fence_kinds();
    int pulses;
    apply_reset();
    bus.flush_rdy = 1'b1;
    push_one(64'h3000, 2'd2);
    push_one(64'h3100, 2'd3);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.flush_en === 1'b1) begin
        n_checks++;
        if (bus.flush_fence !== (pulses == 0) || bus.flush_sfence !== (pulses == 1) ||
            bus.update_wepoch_en !== 1'b1 || bus.update_eepoch_en !== 1'b0 ||
            bus.flush_pc !== ((pulses == 0) ? 64'h3000 : 64'h3100)) begin
          n_fail++;
          $display("FAIL fence_pulse%0d: f=%b sf=%b we_en=%b ee_en=%b pc=%h", pulses,
                   bus.flush_fence, bus.flush_sfence, bus.update_wepoch_en,
                   bus.update_eepoch_en, bus.flush_pc);
        end
        pulses++;
      end
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if (pulses != 2 || bus.wepoch !== 1'b0 || bus.eepoch !== 1'b0 || bus.flush_count !== 32'd2) begin
      n_fail++;
      $display("FAIL fence_final: pulses=%0d we=%b ee=%b count=%0d, required 2 0 0 2",
               pulses, bus.wepoch, bus.eepoch, bus.flush_count);
    end
  endtask

  task automatic test_stall();
    int pulses;
    apply_reset();
    bus.flush_rdy = 1'b0;
    push_one(64'h4444_0000, 2'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.flush_en !== 1'b0 || bus.flush_pc !== '0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d en=%b pc=%h busy=%b, required 0 0 1",
                 c, bus.flush_en, bus.flush_pc, bus.busy);
      end
      @(posedge CLK);
      #1;
    end
    bus.flush_rdy = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.flush_en === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.flush_pc !== 64'h4444_0000 || bus.update_wepoch_en !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_release: pc=%h we_en=%b, required 44440000 1",
                   bus.flush_pc, bus.update_wepoch_en);
        end
      end
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL stall_pulses: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_reset_in_gap();
    bit hit;
    int pulses;
    apply_reset();
    bus.flush_rdy = 1'b1;
    hit = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_pc   = 64'h5000 + 64'(i * 4);
      bus.req_kind = 2'd0;
      @(negedge CLK);
      if (bus.flush_en === 1'b1) hit = 1'b1;
      @(posedge CLK);
      #1;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL gap_setup: first flush seen=%b, required 1", hit);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.flush_count !== 32'd0 || bus.eepoch !== 1'b0 ||
        bus.wepoch !== 1'b0 || bus.flush_en !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b count=%0d ee=%b we=%b en=%b ready=%b, required 0 0 0 0 0 1",
               bus.busy, bus.flush_count, bus.eepoch, bus.wepoch, bus.flush_en, bus.req_ready);
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (bus.flush_en === 1'b1) pulses++;
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (pulses != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: pulses=%0d busy=%b, required 0 0", pulses, bus.busy);
    end
  endtask

  task automatic test_align_check();
    logic [PC_W-1:0] got[$];
    apply_reset();
    bus.flush_rdy = 1'b1;
    push_one(64'h1001, 2'd0);
    push_one(64'h2000, 2'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.flush_en === 1'b1) got.push_back(bus.flush_pc);
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
`ifdef FLUSH_ALIGN_CHECK_EN
    n_checks++;
    if (got.size() != 1 || got[0] !== 64'h2000 || bus.err_misaligned !== 1'b1 ||
        bus.flush_count !== 32'd1 || bus.eepoch !== 1'b1) begin
      n_fail++;
      $display("FAIL align_check: flushes=%0d err=%b count=%0d ee=%b, required 1 (pc 2000) 1 1 1",
               got.size(), bus.err_misaligned, bus.flush_count, bus.eepoch);
    end
`else
    n_checks++;
    if (got.size() != 2 || got[0] !== 64'h1001 || got[1] !== 64'h2000 ||
        bus.err_misaligned !== 1'b0 || bus.flush_count !== 32'd2) begin
      n_fail++;
      $display("FAIL align_off: flushes=%0d err=%b count=%0d, required 2 (1001,2000) 0 2",
               got.size(), bus.err_misaligned, bus.flush_count);
    end
`endif
  endtask

  // Reference: ordered queue of accepted requests, each flush consumes the front.
  task automatic test_random();
    logic [PC_W-1:0] q_pc[$];
    logic [1:0]      q_kind[$];
    logic            m_ee;
    logic            m_we;
    logic [31:0]     m_cnt;
    int              stall;
    int              last;
    logic            ready_s;
    apply_reset();
    m_ee  = 1'b0;
    m_we  = 1'b0;
    m_cnt = 32'd0;
    stall = 0;
    last  = -100;
    for (int cyc = 0; cyc < 640; cyc++) begin
      if (cyc < 580) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_pc    = {$urandom, $urandom} & ~64'h1;
        bus.req_kind  = 2'($urandom_range(0, 3));
        bus.flush_rdy = ($urandom_range(0, 9) < 7);
      end else begin
        bus.req_valid = 1'b0;
        bus.flush_rdy = 1'b1;
      end
      @(negedge CLK);
      ready_s = bus.req_ready;
      n_checks++;
      if (ready_s !== (q_pc.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_ready: cyc %0d ready=%b, required %b", cyc, ready_s, q_pc.size() < DEPTH);
      end
      n_checks++;
      if (bus.eepoch !== m_ee || bus.wepoch !== m_we || bus.flush_count !== m_cnt) begin
        n_fail++;
        $display("FAIL rnd_state: cyc %0d ee=%b we=%b count=%0d, required %b %b %0d",
                 cyc, bus.eepoch, bus.wepoch, bus.flush_count, m_ee, m_we, m_cnt);
      end
      if (bus.flush_en === 1'b1) begin
        n_checks++;
        if (q_pc.size() == 0 || bus.flush_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_spurious: cyc %0d flush with queue=%0d rdy=%b", cyc, q_pc.size(), bus.flush_rdy);
        end else begin
          n_checks++;
          if (bus.flush_pc !== q_pc[0] || bus.flush_fence !== (q_kind[0] == 2'd2) ||
              bus.flush_sfence !== (q_kind[0] == 2'd3) ||
              bus.update_eepoch_en !== (q_kind[0] == 2'd0) ||
              bus.update_wepoch_en !== (q_kind[0] != 2'd0)) begin
            n_fail++;
            $display("FAIL rnd_payload: cyc %0d pc=%h kind-flags f%b sf%b ee%b we%b, required pc=%h kind=%0d",
                     cyc, bus.flush_pc, bus.flush_fence, bus.flush_sfence,
                     bus.update_eepoch_en, bus.update_wepoch_en, q_pc[0], q_kind[0]);
          end
          if (q_kind[0] == 2'd0) m_ee = ~m_ee;
          else m_we = ~m_we;
          m_cnt = m_cnt + 32'd1;
          void'(q_pc.pop_front());
          void'(q_kind.pop_front());
        end
        n_checks++;
        if (cyc - last < MIN_GAP + 2) begin
          n_fail++;
          $display("FAIL rnd_gap: cyc %0d spacing=%0d, required >= %0d", cyc, cyc - last, MIN_GAP + 2);
        end
        last  = cyc;
        stall = 0;
      end else if (q_pc.size() != 0 && bus.flush_rdy === 1'b1) begin
        stall++;
        if (stall == MIN_GAP + 3) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_starve: cyc %0d no flush for %0d ready cycles, required <= %0d",
                   cyc, stall, MIN_GAP + 2);
        end
      end else begin
        stall = 0;
      end
      if (bus.req_valid && ready_s) begin
        q_pc.push_back(bus.req_pc);
        q_kind.push_back(bus.req_kind);
      end
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if (q_pc.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_drain: queue=%0d busy=%b, required 0 0", q_pc.size(), bus.busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_flush();
    test_back_to_back();
    test_fence_kinds();
    test_stall();
    test_reset_in_gap();
    test_align_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
